// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction/mode encodings and terminal-value helper for mod_counter
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Value at which a step in the given direction wraps or saturates
  function automatic int unsigned terminal_value(input int unsigned modulus, input logic dir);
    return (dir == DIR_UP) ? (modulus - 1) : 0;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - synchronous up/down modulo counter with load, wrap/saturate and carry-borrow
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             halted
);

  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
    $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  // MOD_W needs WIDTH+1 bits so MODULUS == 2**WIDTH is representable
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             halted_r;

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             halted_next;

  logic [WIDTH-1:0] term;
  logic             at_term;
  logic [WIDTH:0]   step_up;
  logic             load_over;

  assign term      = WIDTH'(terminal_value(MODULUS, up));
  assign at_term   = (q_r == term);
  assign step_up   = {1'b0, q_r} + 1'b1;
  assign load_over = ({1'b0, d} >= MOD_W);

  // Next-state: load beats en; a step at terminal either wraps or is blocked
  always_comb begin
    q_next      = q_r;
    wrap_next   = 1'b0;
    halted_next = halted_r;
    if (load) begin
      q_next      = load_over ? LAST : d;
      halted_next = 1'b0;
    end else if (en) begin
      if (!at_term) begin
        q_next = (up == DIR_UP) ? step_up[WIDTH-1:0] : (q_r - 1'b1);
      end else if (sat == MODE_SAT) begin
        halted_next = 1'b1;
      end else begin
        q_next    = (up == DIR_UP) ? '0 : LAST;
        wrap_next = 1'b1;
      end
    end
  end

  // State registers with synchronous reset overriding everything
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r      <= '0;
      wrap_r   <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      q_r      <= q_next;
      wrap_r   <= wrap_next;
      halted_r <= halted_next;
    end
  end

  assign q      = q_r;
  assign wrap   = wrap_r;
  assign halted = halted_r;
  // Combinational so a cascaded stage sees the carry in the same cycle
  assign tc     = en & at_term;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - self-checking bench for mod_counter with a cascaded tens stage
module tb_mod_counter;

  localparam int MOD = 10;

  logic       clk;
  logic       reset, en, up, sat, load;
  logic [3:0] d;
  logic [3:0] q, tq;
  logic       tc, wrap, halted;
  logic       ttc, twrap, thalted;

  int vectors;
  int miscompares;

  int m_q;
  bit m_wrap;
  bit m_halted;

  mod_counter #(.WIDTH(4), .MODULUS(MOD)) u_units (
    .clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .load(load), .d(d),
    .q(q), .tc(tc), .wrap(wrap), .halted(halted)
  );

  mod_counter #(.WIDTH(4), .MODULUS(MOD)) u_tens (
    .clk(clk), .reset(reset), .en(tc), .up(1'b1), .sat(1'b0), .load(1'b0), .d(4'd0),
    .q(tq), .tc(ttc), .wrap(twrap), .halted(thalted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: count arithmetic modulo MOD, one edge at a time
  function automatic void model_edge(input bit r, input bit l, input bit e, input bit u,
                                     input bit s, input int dv);
    int nxt;
    if (r) begin
      m_q = 0; m_wrap = 0; m_halted = 0;
    end else if (l) begin
      m_q = (dv < MOD) ? dv : MOD - 1;
      m_wrap = 0; m_halted = 0;
    end else if (e) begin
      nxt = u ? m_q + 1 : m_q - 1;
      if (nxt >= MOD || nxt < 0) begin
        if (s) begin
          m_halted = 1; m_wrap = 0;
        end else begin
          m_q = (nxt + MOD) % MOD; m_wrap = 1;
        end
      end else begin
        m_q = nxt; m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
  endfunction

  task automatic cycle(input bit r, input bit l, input bit e, input bit u, input bit s,
                       input int dv);
    bit exp_tc;
    reset = r; load = l; en = e; up = u; sat = s; d = 4'(dv);
    #1;
    exp_tc = e && (m_q == (u ? MOD - 1 : 0));
    chk("tc", 32'(tc), 32'(exp_tc));
    model_edge(r, l, e, u, s, dv);
    @(posedge clk);
    #1;
    chk("q", 32'(q), 32'(m_q));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("halted", 32'(halted), 32'(m_halted));
  endtask

  initial begin
    int count;
    int twraps;
    vectors = 0;
    miscompares = 0;
    m_q = 0; m_wrap = 0; m_halted = 0;

    reset = 1; load = 0; en = 1; up = 1; sat = 0; d = 0;
    @(posedge clk);
    #1;
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);

    // Reset held with en=1, then count up through the wrap
    cycle(1, 0, 1, 1, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 1, 1, 0, 0);
    chk("up_end_q", 32'(q), 32'd1);

    // Load 2 then count down through 0 to 9, 8
    cycle(0, 1, 0, 0, 0, 2);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 0);
    chk("down_end_q", 32'(q), 32'd8);

    // Saturate at 9, reverse, then load clears halted
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 1, 0);
    chk("sat_halted", 32'(halted), 32'd1);
    cycle(0, 0, 1, 0, 1, 0);
    cycle(0, 0, 1, 0, 1, 0);
    chk("rev_q", 32'(q), 32'd7);
    chk("rev_halted", 32'(halted), 32'd1);
    cycle(0, 1, 0, 0, 1, 3);
    chk("load3_halted", 32'(halted), 32'd0);

    // Load priority, clamp, reset priority
    cycle(0, 1, 1, 1, 0, 7);
    chk("load_wins_q", 32'(q), 32'd7);
    cycle(0, 1, 0, 1, 0, 12);
    chk("clamp_q", 32'(q), 32'd9);
    cycle(1, 1, 1, 1, 0, 5);
    chk("reset_wins_q", 32'(q), 32'd0);

    // Idle hold at 9
    cycle(0, 1, 0, 1, 0, 9);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 0);
    chk("hold_q", 32'(q), 32'd9);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 15)));
    end

    // Cascade: units carry drives tens enable
    cycle(1, 0, 0, 1, 0, 0);
    chk("casc_tens_reset", 32'(tq), 32'd0);
    count = 0;
    twraps = 0;
    for (int i = 0; i < 210; i++) begin
      cycle(0, 0, 1, 1, 0, 0);
      count = (count + 1) % 100;
      chk("casc_tens_q", 32'(tq), 32'(count / 10));
      chk("casc_tens_wrap", 32'(twrap), 32'(count == 0));
      if (twrap === 1'b1) twraps++;
    end
    chk("casc_tens_wraps", 32'(twraps), 32'd2);
    chk("casc_tens_halted", 32'(thalted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous up/down modulo counter; the fully synchronous, general-width successor to the team's 4-bit toggle-flop ripple counter. Counts modulo MODULUS in either direction with enable, parallel load, wrap or saturate mode, and a carry/borrow output for cascading into multi-digit counters. All state changes on one clock edge, so there is no ripple delay between bits.

## Interface
- WIDTH, 4, counter width in bits
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; elaboration error unless 2 <= MODULUS <= 2**WIDTH
- clk  input  1  clock; all state changes on posedge clk
- reset  input  1  synchronous, active-high reset; sampled on posedge clk
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- sat  input  1  mode: 0 = wrap at terminal, 1 = saturate (hold) at terminal
- load  input  1  parallel load strobe
- d  input  WIDTH  load value
- q  output  WIDTH  current count, registered
- tc  output  1  terminal count / carry-borrow, combinational
- wrap  output  1  one-cycle registered pulse on a wrap event
- halted  output  1  sticky registered flag: saturate mode blocked a step

## Operation
- Priority per edge: reset > load > en. With none active, all registers hold; wrap goes to 0.
- reset: q=0, wrap=0, halted=0. Overrides load and en in the same cycle.
- load: q <= d if d < MODULUS, else q <= MODULUS-1 (clamp). halted <= 0, wrap <= 0. en ignored that cycle.
- Terminal value: MODULUS-1 when up=1, 0 when up=0.
- en=1, q not at terminal: q <= q+1 (up) or q-1 (down); wrap <= 0; halted unchanged.
- en=1, q at terminal, sat=0: q <= 0 (up) or MODULUS-1 (down); wrap <= 1.
- en=1, q at terminal, sat=1: q holds; halted <= 1; wrap <= 0.
- halted is cleared only by reset or load. Stepping away from the terminal (direction reversal) does not clear it.
- tc = en & (q == terminal value for the current up). It is independent of sat and is intended to drive en of the next cascaded stage.
- Arithmetic: next-count computed at WIDTH+1 bits and compared against MODULUS; q never holds a value >= MODULUS.
- up and sat may change on any cycle; they take effect on the next edge with no pipeline.

## Timing
- Latency from load, en, or reset to q: 1 cycle (value visible after the sampling edge).
- wrap is asserted in the same cycle q shows the wrapped value, for exactly one cycle per wrap event.
- halted rises in the cycle after the first blocked step.
- tc is combinational from q, en, and up. Same-cycle changes of en or up are seen in tc; there is no register path.
- Reset mid-count or mid-load: the next q is 0 regardless of the other inputs.

## Structure
- Shared package counter_pkg holds:
  - DIR_DOWN=1'b0, DIR_UP=1'b1
  - MODE_WRAP=1'b0, MODE_SAT=1'b1
  - a function computing the terminal value from MODULUS and direction
- Single module with no sub-module: one next-state block and one register block. Cascading is done at the instantiation level, not inside the block.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 unless noted.
- Hold reset=1 for 3 cycles with en=1, then release with en=1, up=1, sat=0 -> q=0 during reset; q then steps 1..9,0,1; tc=1 while q=9; wrap=1 only in the cycle q=0 follows 9.
- Load d=2, then en=1, up=0, sat=0 -> q=2,1,0,9,8; tc=1 while q=0; wrap pulses with q=9.
- sat=1, up=1, start q=8 -> q=9,9,9; halted=1 from the cycle after the first blocked step; wrap stays 0. Then up=0 -> q=8,7 with halted still 1. Then load d=3 -> q=3, halted=0.
- load=1, en=1, d=7 -> q=7 (load wins). Load d=12 -> q=9 (clamp). Reset=1 with load=1, d=5 -> q=0.
- en=0 for 5 cycles at q=9, up=1 -> q holds 9, tc=0, wrap=0.
- Cascade two instances (units tc -> tens en), up=1, sat=0, from reset -> combined count 00..99 then 00; tens wrap pulses once per 100 cycles.
